// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency fixed at WIDTH+2 cycles from accepted start to done; start is ignored while busy, flush aborts.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             w_capture;
    logic             w_iter;
    logic             w_finish;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs_mag;
    logic             r_op_rem;
    logic             r_quo_neg;
    logic             r_rem_neg;
    logic             r_spec_vld;
    logic [WIDTH-1:0] r_spec_res;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    // Operand preparation at capture time
    logic             w_signed;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_spec_res;

    assign w_signed  = ~op[0];
    assign w_dvd_neg = w_signed & dividend[WIDTH-1];
    assign w_dvs_neg = w_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (-dividend) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (-divisor) : divisor;
    assign w_div0    = (divisor == '0);
    assign w_ovf     = w_signed && (dividend == MIN_NEG) && (divisor == '1);

    // Divide-by-zero and signed overflow have fixed architectural answers
    always_comb begin
        w_spec_res = '0;
        if (w_div0) begin
            w_spec_res = op[1] ? dividend : '1;
        end else if (w_ovf) begin
            w_spec_res = op[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step; remainder always stays below the divisor magnitude,
    // so the difference fits in WIDTH bits once the compare says it is non-negative.
    logic [WIDTH:0]   w_rem_sh;
    logic             w_trial_ok;
    logic [WIDTH-1:0] w_trial_dif;

    assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial_ok  = (w_rem_sh >= {1'b0, r_dvs_mag});
    assign w_trial_dif = w_rem_sh[WIDTH-1:0] - r_dvs_mag;

    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_final;

    assign w_quo_fix = r_quo_neg ? (-r_quo) : r_quo;
    assign w_rem_fix = r_rem_neg ? (-r_rem) : r_rem;
    assign w_final   = r_spec_vld ? r_spec_res : (r_op_rem ? w_rem_fix : w_quo_fix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_iter      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        w_state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                w_finish    = ~flush;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs_mag  <= '0;
            r_op_rem   <= 1'b0;
            r_quo_neg  <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_spec_vld <= 1'b0;
            r_spec_res <= '0;
        end else if (w_capture) begin
            r_count    <= CNT_W'(WIDTH);
            r_rem      <= '0;
            r_quo      <= w_dvd_mag;
            r_dvs_mag  <= w_dvs_mag;
            r_op_rem   <= op[1];
            r_quo_neg  <= w_dvd_neg ^ w_dvs_neg;
            r_rem_neg  <= w_dvd_neg;
            r_spec_vld <= w_div0 | w_ovf;
            r_spec_res <= w_spec_res;
        end else if (w_iter) begin
            r_count <= r_count - CNT_W'(1);
            r_rem   <= w_trial_ok ? w_trial_dif : w_rem_sh[WIDTH-1:0];
            r_quo   <= {r_quo[WIDTH-2:0], w_trial_ok};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic, special cases, handshake corners and async reset.
module tb_seq_divider;
    localparam int W = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Leaves the bench at the negedge one cycle after acceptance.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // cyc is the cycle index (1 = current negedge) where done is seen, 0 if never.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int c;
        int bc;
        issue(o, a, b);
        wait_done(c, bc);
        check({tag, " latency"}, c, 34);
        check({tag, " busy"}, bc, 33);
        check({tag, " result"}, result, exp);
    endtask

    initial begin
        int c;
        int bc;
        int nd;

        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);

        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("divu by 0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("rem by 0", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("div by 0 neg", OP_DIV, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // A second start during busy must not queue or restart anything.
        issue(OP_DIVU, 32'd50, 32'd5);
        repeat (4) @(negedge clk);
        op       = OP_DIVU;
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c, bc);
        check("busy start latency", c, 29);
        check("busy start result", result, 32'd10);
        count_dones(40, nd);
        check("busy start extra done", nd, 0);

        // start held in the done cycle issues back-to-back.
        issue(OP_DIVU, 32'd200, 32'd10);
        wait_done(c, bc);
        check("b2b first result", result, 32'd20);
        op       = OP_REMU;
        dividend = 32'd200;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c, bc);
        check("b2b second latency", c, 34);
        check("b2b second result", result, 32'd4);

        // Flush at iteration 10: no done, busy drops, result kept.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        count_dones(40, nd);
        check("flush no done", nd, 0);
        check("flush result kept", result, 32'd4);

        // Flush together with start in IDLE blocks acceptance.
        @(negedge clk);
        op       = OP_DIVU;
        dividend = 32'd8;
        divisor  = 32'd2;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", busy, 0);

        // Async reset between edges mid-operation.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst result", result, 0);
        #1 rst = 1'b0;
        run_op("post-reset divu", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle radix-2 restoring integer divider that implements the inverse of the datapath's add/subtract unit. It is a companion to the carry-lookahead adder and covers RV32M DIV/DIVU/REM/REMU. It sits in the execute stage beside the ALU. The pipeline issues a request with a start pulse, stalls on busy, and takes the result on a one-cycle done pulse.

Parameters:
WIDTH, 32, operand/result width in bits (must be even, >= 4)
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request strobe; sampled only when busy=0
op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
dividend  input  WIDTH  numerator; captured with start
divisor  input  WIDTH  denominator; captured with start
flush  input  1  aborts an in-flight operation (pipeline kill)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result valid in this cycle
result  output  WIDTH  quotient or remainder per captured op; held until next done

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst is asynchronous and active-high. It forces state=IDLE, busy=0, done=0, result=0, and clears all internal registers, including mid-operation.
- States: IDLE, RUN, FINISH.
- IDLE:
  - If start=1 and flush=0 at edge T0, capture op, operand magnitudes (absolute value for signed ops), sign flags, and special-case flags. Clear the partial remainder, load count=WIDTH, go to RUN.
  - start while busy=1 is ignored; no queueing.
- RUN, one quotient bit per edge:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem=trial and quo[0]=1; else rem unchanged and quo[0]=0.
  - count decrements. After the WIDTH-th iteration (edge T0+WIDTH), go to FINISH.
- FINISH (edge T0+WIDTH+1):
  - Apply sign fixup: quotient is negated if signed and the operand signs differ; remainder takes the sign of the dividend.
  - Select quotient or remainder per op, register it into result, set done=1, return to IDLE.
- Latency and handshake:
  - Latency is fixed for every case: done is high in the cycle after edge T0+WIDTH+1, i.e. WIDTH+2 cycles after start is accepted.
  - busy=1 from the cycle after T0 through the cycle before done. busy=0 while done=1.
  - start may be asserted in the same cycle as done and is accepted (back-to-back issue).
- Special cases are resolved at capture and override the FINISH result, with latency unchanged:
  - divisor=0: DIV/DIVU give all-ones; REM/REMU give the dividend unchanged.
  - Signed overflow (DIV/REM, dividend=-2^(WIDTH-1), divisor=-1): DIV gives -2^(WIDTH-1); REM gives 0.
- Magnitude of -2^(WIDTH-1) is representable as an unsigned WIDTH-bit value; no extra bit is needed on quo.
- Flush:
  - flush=1 in RUN or FINISH returns to IDLE at the next edge. No done pulse; result keeps its previous value.
  - flush=1 in IDLE blocks start acceptance in that cycle.
  - flush and start both high in IDLE: flush wins.
- done is never high for two consecutive cycles.
- The FINISH result write and done happen on the same edge.

Test Plan:
- DIVU, dividend=100, divisor=7, start for 1 cycle -> busy high 33 cycles, done in cycle 34 after accept, result=14. REMU same operands -> result=2.
- DIV, dividend=-7 (0xFFFFFFF9), divisor=2 -> result=0xFFFFFFFD (-3). REM same -> 0xFFFFFFFF (-1). REM with dividend=7, divisor=-2 -> result=1.
- Divide by zero: DIVU 0x12345678/0 -> 0xFFFFFFFF. REM 0x12345678/0 -> 0x12345678. Both complete with done at the same 34-cycle latency.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0x00000000.
- Handshake corners:
  - Second start during busy -> ignored; exactly one done.
  - start held high in the done cycle -> new op accepted; next done exactly 34 cycles later.
  - flush at iteration 10 -> no done, busy=0 next cycle, result unchanged from the prior op.
- Async rst asserted mid-RUN, between clock edges -> busy, done, result go to 0 immediately. After release, DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
